uart_rx_frame_ctrl: RTL and testbench
=====================================

// Module: uart_rx_frame_ctrl
// PURPOSE
//  UART receive frame controller; sits around the RX majority-vote sampler.
//  Owns the oversampling edge counter and bit counter, and drives data_sample_en and edge_count to the sampler.
//  Consumes sampled_data, deserialises LSB first, and checks start, parity and stop bits.
//  Outputs the parallel byte with a one-cycle data_valid pulse, plus error pulses.
// PARAMETERS
//  DATA_WIDTH  8  payload bits per frame
//  PS_WIDTH    6  width of prescale / edge_count
// PORTS
//  CLK             in   1           system clock (oversampled RX clock)
//  RST             in   1           synchronous, active-low reset, sampled on posedge CLK
//  rx_in           in   1           serial line, already synchronised; idle high
//  prescale        in   PS_WIDTH    oversampling ratio; 4/8/16/32 supported
//  PAR_EN          in   1           1 = parity bit present
//  PAR_TYP         in   1           0 = even, 1 = odd
//  sampled_data    in   1           voted bit from sampler, updated by edge (prescale>>1)+1
//  data_sample_en  out  1           high in START/DATA/PARITY/STOP
//  edge_count      out  PS_WIDTH    0..prescale-1 within current bit
//  P_DATA          out  DATA_WIDTH  last good byte; held until next good frame
//  data_valid      out  1           1-cycle pulse, good frame
//  par_err         out  1           1-cycle pulse, parity mismatch
//  stp_err         out  1           1-cycle pulse, stop bit sampled 0
//  strt_glitch     out  1           1-cycle pulse, start bit sampled 1
// BEHAVIOUR
//  Reset (RST=0 at posedge): state IDLE; counters 0; shift reg 0; P_DATA=0; all pulses and data_sample_en=0.
//  Reset mid-frame aborts the frame with no pulses.
//  Config latch on IDLE->START: prescale, PAR_EN, PAR_TYP.
//   - Mid-frame changes are ignored.
//   - A latched prescale < 4 is treated as 4.
//  bit_end = (edge_count == ps_l-1).
//   - edge_count increments while data_sample_en=1 and wraps to 0 at bit_end.
//   - bit_count increments at bit_end.
//   - Both counters are 0 in IDLE.
//  IDLE:   rx_in==0 -> START.
//  START:  at bit_end: sampled_data==0 -> DATA; else strt_glitch pulse -> IDLE.
//  DATA:   at bit_end, shift sampled_data in at MSB (LSB-first line order).
//          After DATA_WIDTH bits: PAR_EN ? PARITY : STOP.
//  PARITY: at bit_end, compare sampled_data with ^shift (even) or ~^shift (odd).
//          Mismatch -> par_err pulse and set frame_bad. Always -> STOP.
//  STOP:   at bit_end, sampled_data==0 -> stp_err pulse.
//          If !frame_bad && stop==1: load P_DATA and pulse data_valid.
//          Always -> IDLE; frame_bad cleared.
//  Pulses are registered and high the cycle after the qualifying bit_end.
//  Back-to-back frames: IDLE may see rx_in==0 on the first cycle after STOP and start immediately.
//   - No idle gap is required.
//   - Pulses from the previous frame coincide with the first START cycle.
//  Latency, start falling edge first seen at cycle t, no parity, prescale P:
//   - data_valid at cycle t + 1 + (DATA_WIDTH+2)*P.
//   - Add P when parity is enabled.
//  data_valid and stp_err are mutually exclusive; par_err and data_valid are mutually exclusive in a frame.
// STRUCTURE
//  uart_rx_defs.vh: state encodings (IDLE/START/DATA/PARITY/STOP, binary 3-bit) and PRESCALE_MIN=4.
//  Sub-module uart_rx_edge_bit_counter: edge_count/bit_count with enable, wrap at ps_l-1, bit_end output.
//  Top level: FSM, config latch, shift register, parity/stop checks, output registers.
// TESTING
//  1. P=8, PAR_EN=0, byte 0xA5 clean.
//     -> P_DATA=0xA5, data_valid 1 cycle at t+81, no error pulses.
//  2. P=16, PAR_EN=1, PAR_TYP=0, byte 0x3C, parity bit 0.
//     -> data_valid, P_DATA=0x3C.
//     Repeat with parity bit 1 -> par_err pulse, no data_valid, P_DATA keeps 0x3C.
//  3. P=8, line low 2 cycles then high.
//     -> strt_glitch pulse at t+9, back in IDLE, data_sample_en=0.
//  4. P=4, byte 0xFF, stop bit driven 0.
//     -> stp_err pulse, no data_valid.
//     Next frame 0x01 back-to-back -> P_DATA=0x01.
//  5. P=32, RST low mid-DATA for 1 cycle, then clean 0x5A frame.
//     -> all outputs 0 after reset, then P_DATA=0x5A.
//  6. Change prescale 8->16 and PAR_EN mid-frame.
//     -> current frame completes with latched config; next frame uses new values.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// rtl/uart_rx_frame_ctrl_pkg.sv - shared state encoding and constants for the UART RX frame controller
package uart_rx_frame_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Smallest oversampling ratio the sampler can vote on; smaller requests are clamped up.
    localparam int PRESCALE_MIN = 4;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter and bit counter with bit_end strobe
module uart_rx_edge_bit_counter #(
    parameter int PS_WIDTH = 6,
    parameter int BC_WIDTH = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic [PS_WIDTH-1:0] ps_l,
    output logic [PS_WIDTH-1:0] edge_count,
    output logic [BC_WIDTH-1:0] bit_count,
    output logic                bit_end
);

    // Last oversampling edge of the current bit; only meaningful while counting.
    assign bit_end = en && (edge_count == ps_l - PS_WIDTH'(1));

    // Edge counter wraps at bit_end and advances the bit counter; both held at 0 when disabled.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (!en) begin
            edge_count <= '0;
            bit_count  <= '0;
        end else if (bit_end) begin
            edge_count <= '0;
            bit_count  <= bit_count + BC_WIDTH'(1);
        end else begin
            edge_count <= edge_count + PS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART receive frame controller: FSM, deserialiser, parity/stop checks
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PS_WIDTH   = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_in,
    input  logic [PS_WIDTH-1:0]   prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_data,
    output logic                  data_sample_en,
    output logic [PS_WIDTH-1:0]   edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch
);

    // Bit index runs 0 (start) .. DATA_WIDTH+2 (stop with parity) and may tick once more at the stop bit_end.
    localparam int BC_WIDTH = $clog2(DATA_WIDTH + 4);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic [PS_WIDTH-1:0]   ps_l;
    logic                  par_en_l;
    logic                  par_typ_l;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  frame_bad;
    logic                  bit_end;
    logic [BC_WIDTH-1:0]   bit_count;
    logic                  start_seen;
    logic                  last_data_bit;
    logic                  parity_exp;

    assign start_seen    = (state == ST_IDLE) && !rx_in;
    assign last_data_bit = (bit_count == BC_WIDTH'(DATA_WIDTH));
    assign parity_exp    = par_typ_l ? ~^shift_reg : ^shift_reg;

    uart_rx_edge_bit_counter #(
        .PS_WIDTH (PS_WIDTH),
        .BC_WIDTH (BC_WIDTH)
    ) u_counter (
        .CLK        (CLK),
        .RST        (RST),
        .en         (data_sample_en),
        .ps_l       (ps_l),
        .edge_count (edge_count),
        .bit_count  (bit_count),
        .bit_end    (bit_end)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; every bit phase advances only on its final oversampling edge.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (!rx_in) state_nxt = ST_START;
            ST_START:  if (bit_end) state_nxt = sampled_data ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_end && last_data_bit) state_nxt = par_en_l ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            ST_STOP:   if (bit_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Sampler and counters are active for every bit of a frame.
    always_comb begin
        data_sample_en = 1'b0;
        case (state)
            ST_START, ST_DATA, ST_PARITY, ST_STOP: data_sample_en = 1'b1;
            default:                               data_sample_en = 1'b0;
        endcase
    end

    // Frame configuration is frozen at the start edge so mid-frame input changes cannot corrupt it.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            ps_l      <= PS_WIDTH'(PRESCALE_MIN);
            par_en_l  <= 1'b0;
            par_typ_l <= 1'b0;
        end else if (start_seen) begin
            ps_l      <= (prescale < PS_WIDTH'(PRESCALE_MIN)) ? PS_WIDTH'(PRESCALE_MIN) : prescale;
            par_en_l  <= PAR_EN;
            par_typ_l <= PAR_TYP;
        end
    end

    // Deserialiser, frame checks and registered one-cycle result pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            shift_reg   <= '0;
            frame_bad   <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
            case (state)
                ST_START: begin
                    if (bit_end && sampled_data) begin
                        strt_glitch <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        // Line order is LSB first, so each new bit enters at the top.
                        shift_reg <= {sampled_data, shift_reg[DATA_WIDTH-1:1]};
                    end
                end
                ST_PARITY: begin
                    if (bit_end && (sampled_data != parity_exp)) begin
                        par_err   <= 1'b1;
                        frame_bad <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (!sampled_data) begin
                            stp_err <= 1'b1;
                        end else if (!frame_bad) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        frame_bad <= 1'b0;
                    end
                end
                default: frame_bad <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - self-checking bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          sampled_data = 1'b1;
    logic          data_sample_en;
    logic [PW-1:0] edge_count;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;

    uart_rx_frame_ctrl #(
        .DATA_WIDTH (DW),
        .PS_WIDTH   (PW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .rx_in          (rx_in),
        .prescale       (prescale),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .sampled_data   (sampled_data),
        .data_sample_en (data_sample_en),
        .edge_count     (edge_count),
        .P_DATA         (P_DATA),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .strt_glitch    (strt_glitch)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // Event kinds: 0 data_valid, 1 par_err, 2 stp_err, 3 strt_glitch
    typedef struct {
        int           kind;
        logic [DW-1:0] data;
    } ev_t;
    ev_t exp_q[$];

    logic [DW-1:0] last_good = '0;
    int samp_p = 8;
    int last_dv_cyc = -1;
    int last_gl_cyc = -1;

    // Sampler model: captures the line at mid-bit using the bench's own idea of the frame prescale.
    always @(posedge CLK) begin
        if (!RST) sampled_data <= 1'b1;
        else if (data_sample_en && int'(edge_count) == (samp_p >> 1)) sampled_data <= rx_in;
    end

    // Scoreboard monitor.
    always @(negedge CLK) begin : monitor
        logic [3:0] p;
        ev_t e;
        if (RST) begin
            p = {strt_glitch, stp_err, par_err, data_valid};
            if (data_valid) last_dv_cyc = cyc;
            if (strt_glitch) last_gl_cyc = cyc;
            if (data_valid || stp_err) begin
                checks++;
                if (data_valid && stp_err) begin
                    failures++;
                    $display("FAIL excl_dv_stp data_valid=%b stp_err=%b required not both", data_valid, stp_err);
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (p[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_pulse kind=%0d cyc=%0d required none", i, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != i) begin
                            failures++;
                            $display("FAIL pulse_kind got=%0d exp=%0d cyc=%0d", i, e.kind, cyc);
                        end
                        checks++;
                        if (P_DATA !== e.data) begin
                            failures++;
                            $display("FAIL p_data got=%0h exp=%0h cyc=%0d", P_DATA, e.data, cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic push_ev(input int kind, input logic [DW-1:0] d);
        ev_t e;
        e.kind = kind;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    task automatic send_bit(input logic v, input int p);
        rx_in = v;
        repeat (p) begin @(posedge CLK); #1; end
    endtask

    task automatic send_frame(input int p, input logic [DW-1:0] d, input logic pe, input logic pt,
                              input logic flip_par, input logic stop_bit, output int k);
        samp_p = p;
        k = cyc;
        send_bit(1'b0, p);
        for (int i = 0; i < DW; i++) send_bit(d[i], p);
        if (pe) send_bit((pt ? ~^d : ^d) ^ flip_par, p);
        send_bit(stop_bit, p);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge CLK); #1; n++; end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_%s pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name, input logic [DW-1:0] exp_pdata);
        checks++;
        if (P_DATA !== exp_pdata) begin
            failures++;
            $display("FAIL %s_p_data got=%0h exp=%0h", name, P_DATA, exp_pdata);
        end
        checks++;
        if ({data_valid, par_err, stp_err, strt_glitch} !== 4'b0) begin
            failures++;
            $display("FAIL %s_pulses got=%b exp=0000", name, {data_valid, par_err, stp_err, strt_glitch});
        end
        checks++;
        if (data_sample_en !== 1'b0) begin
            failures++;
            $display("FAIL %s_dse got=%b exp=0", name, data_sample_en);
        end
        checks++;
        if (edge_count !== '0) begin
            failures++;
            $display("FAIL %s_edge_count got=%0d exp=0", name, edge_count);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        check_idle_outputs("reset", '0);
        RST = 1'b1;
        idle(3);
    endtask

    task automatic test_clean_byte();
        int k;
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        last_good = 8'hA5;
        push_ev(0, 8'hA5);
        send_frame(8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, k);
        idle(4);
        wait_drain("clean");
        checks++;
        if (last_dv_cyc != k + 81) begin
            failures++;
            $display("FAIL latency_dv got=%0d exp=%0d", last_dv_cyc, k + 81);
        end
    endtask

    task automatic test_parity();
        int k;
        prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        last_good = 8'h3C;
        push_ev(0, 8'h3C);
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, k);
        idle(3);
        push_ev(1, 8'h3C);
        send_frame(16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, k);
        idle(3);
        PAR_TYP = 1'b1;
        last_good = 8'h07;
        push_ev(0, 8'h07);
        send_frame(16, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, k);
        idle(4);
        wait_drain("parity");
        PAR_TYP = 1'b0;
    endtask

    task automatic test_start_glitch();
        int k;
        prescale = 6'd8; PAR_EN = 1'b0;
        samp_p = 8;
        push_ev(3, last_good);
        k = cyc;
        send_bit(1'b0, 2);
        idle(20);
        wait_drain("glitch");
        checks++;
        if (last_gl_cyc != k + 9) begin
            failures++;
            $display("FAIL latency_glitch got=%0d exp=%0d", last_gl_cyc, k + 9);
        end
        check_idle_outputs("glitch", last_good);
    endtask

    task automatic test_back_to_back();
        int k;
        prescale = 6'd4; PAR_EN = 1'b0;
        push_ev(2, last_good);
        send_frame(4, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, k);
        idle(1);
        last_good = 8'h01;
        push_ev(0, 8'h01);
        send_frame(4, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1, k);
        idle(4);
        wait_drain("b2b");
    endtask

    task automatic test_reset_mid_frame();
        int k;
        prescale = 6'd32; PAR_EN = 1'b0;
        samp_p = 32;
        send_bit(1'b0, 32);
        send_bit(1'b0, 32);
        send_bit(1'b1, 10);
        RST = 1'b0;
        rx_in = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b1;
        last_good = '0;
        check_idle_outputs("mid_reset", '0);
        idle(5);
        last_good = 8'h5A;
        push_ev(0, 8'h5A);
        send_frame(32, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, k);
        idle(4);
        wait_drain("mid_reset");
    endtask

    task automatic test_config_change();
        int k;
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        last_good = 8'h96;
        push_ev(0, 8'h96);
        fork
            send_frame(8, 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, k);
            begin
                repeat (20) @(posedge CLK);
                #1;
                prescale = 6'd16;
                PAR_EN = 1'b1;
            end
        join
        idle(1);
        last_good = 8'hC3;
        push_ev(0, 8'hC3);
        send_frame(16, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, k);
        idle(4);
        wait_drain("cfg");
    endtask

    initial begin
        test_reset();
        test_clean_byte();
        test_parity();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_config_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
